// File: rtl/game_pkg.sv
// Shared FSM encoding, reset constants and LFSR helpers for the mole game.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        MOLE  = 3'd2,
        HIT   = 3'd3,
        MISS  = 3'd4,
        DONE  = 3'd5
    } game_state_t;

    // "No hit yet" value for the fastest-reaction register.
    localparam logic [9:0] BEST_TIME_INIT = 10'd1023;

    // x^8 + x^6 + x^5 + x^4 + 1, read from q[7:0] of a left-shifting register.
    localparam logic [7:0] LFSR_TAP_MASK = 8'b1011_1000;

    function automatic logic lfsr_feedback(input logic [7:0] q);
        return ^(q & LFSR_TAP_MASK);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR that picks the mole position and the wait length.
// Latency: the new value appears one clock after each edge; it free-runs.
// Backpressure: none, it advances every cycle.
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // Shift left and feed the tap parity into bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= seed;
        end else begin
            q <= {q[6:0], lfsr_feedback(q)};
        end
    end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: random wait, lit mole, hit/miss scoring, game end.
// Latency: all outputs are registered; LEDs follow a state change by one cycle.
// Backpressure: none; every input is a single-cycle pulse acted on when it arrives.
module mole_game_ctrl
    import game_pkg::*;
#(
    parameter int         N_ROUNDS  = 10,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       whack,
    input  logic       timer_0point2_edge,
    input  logic       timer_1_edge,
    input  logic       timer_3_edge,
    input  logic [9:0] display_timer,
    output logic       reset_timer,
    output logic [7:0] mole_led,
    output logic [3:0] score,
    output logic [9:0] best_time,
    output logic [3:0] round_num,
    output logic       miss_led,
    output logic       game_over
);

    localparam logic [3:0] LAST_ROUND = 4'(N_ROUNDS);

    game_state_t state;
    game_state_t next_state;

    logic [7:0] lfsr;
    logic       delay_sel;
    logic [2:0] pos;
    logic [9:0] rt;

    logic       t02_live;
    logic       t1_live;
    logic       t3_live;
    logic       entering;
    logic       game_start;
    logic       round_end;

    logic       reset_timer_d;
    logic [7:0] mole_led_d;
    logic       miss_led_d;
    logic       game_over_d;

    // Only bit 7 and bits 2:0 feed the game; the middle bits just keep the sequence long.
    logic       unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr[6:3];

    lfsr8 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .q       (lfsr)
    );

    // reset_timer is high only in a state's first cycle, when the timer block is
    // restarting, so any edge it reports in that cycle is stale and gets dropped.
    assign t02_live   = timer_0point2_edge & ~reset_timer;
    assign t1_live    = timer_1_edge & ~reset_timer;
    assign t3_live    = timer_3_edge & ~reset_timer;

    assign entering   = (next_state != state);
    assign game_start = ((state == IDLE) || (state == DONE)) && start;
    assign round_end  = ((state == HIT) || (state == MISS)) && t02_live;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; whack always beats a timer edge arriving in the same cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) next_state = DELAY;
            end
            DELAY: begin
                if (whack) begin
                    next_state = MISS;
                end else if (delay_sel ? t3_live : t1_live) begin
                    next_state = MOLE;
                end
            end
            MOLE: begin
                if (whack) begin
                    next_state = HIT;
                end else if (t1_live) begin
                    next_state = MISS;
                end
            end
            HIT, MISS: begin
                if (t02_live) begin
                    next_state = ((round_num + 4'd1) == LAST_ROUND) ? DONE : DELAY;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: LEDs come from the current state, the timer restart from the upcoming one.
    always_comb begin
        mole_led_d    = 8'd0;
        miss_led_d    = 1'b0;
        game_over_d   = 1'b0;
        reset_timer_d = 1'b0;
        if ((state == MOLE) || (state == HIT)) begin
            mole_led_d = 8'd1 << pos;
        end
        miss_led_d    = (state == MISS);
        game_over_d   = (state == DONE);
        reset_timer_d = entering && (next_state inside {DELAY, MOLE, HIT, MISS});
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reset_timer <= 1'b0;
            mole_led    <= 8'd0;
            miss_led    <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            reset_timer <= reset_timer_d;
            mole_led    <= mole_led_d;
            miss_led    <= miss_led_d;
            game_over   <= game_over_d;
        end
    end

    // Game datapath: per-round random picks, reaction capture, score, best time, round count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay_sel <= 1'b0;
            pos       <= 3'd0;
            rt        <= 10'd0;
            score     <= 4'd0;
            best_time <= BEST_TIME_INIT;
            round_num <= 4'd0;
        end else begin
            if (game_start) begin
                score     <= 4'd0;
                round_num <= 4'd0;
                best_time <= BEST_TIME_INIT;
            end
            if (entering && (next_state == DELAY)) begin
                delay_sel <= lfsr[7];
                pos       <= lfsr[2:0];
            end
            if ((state == MOLE) && whack) begin
                rt <= display_timer;
            end
            // Score once, in the first HIT cycle, using the reaction time just captured.
            if ((state == HIT) && reset_timer) begin
                if (score != 4'd15) score <= score + 4'd1;
                if (rt < best_time) best_time <= rt;
            end
            if (round_end) begin
                round_num <= round_num + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl with a cycle model of the game rules.
// Latency: model predicts registered outputs one edge after the inputs it sampled.
// Backpressure: none; stimulus is single-cycle pulses applied between clock edges.
module tb_mole_game_ctrl;

    localparam int ROUNDS = 3;

    localparam int P_IDLE  = 0;
    localparam int P_DELAY = 1;
    localparam int P_MOLE  = 2;
    localparam int P_HIT   = 3;
    localparam int P_MISS  = 4;
    localparam int P_DONE  = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       whack = 1'b0;
    logic       timer_0point2_edge = 1'b0;
    logic       timer_1_edge = 1'b0;
    logic       timer_3_edge = 1'b0;
    logic [9:0] display_timer = 10'd0;
    logic       reset_timer;
    logic [7:0] mole_led;
    logic [3:0] score;
    logic [9:0] best_time;
    logic [3:0] round_num;
    logic       miss_led;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    mole_game_ctrl #(
        .N_ROUNDS  (ROUNDS),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .whack              (whack),
        .timer_0point2_edge (timer_0point2_edge),
        .timer_1_edge       (timer_1_edge),
        .timer_3_edge       (timer_3_edge),
        .display_timer      (display_timer),
        .reset_timer        (reset_timer),
        .mole_led           (mole_led),
        .score              (score),
        .best_time          (best_time),
        .round_num          (round_num),
        .miss_led           (miss_led),
        .game_over          (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- game model ----------------
    int         ph, np, age;
    logic       m_dsel;
    logic [2:0] m_pos;
    int         m_rt, m_score, m_best, m_round;
    logic [7:0] m_lfsr;
    logic       fb;
    logic       live;
    logic       e_rst_t, e_miss, e_over;
    logic [7:0] e_mole;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph = P_IDLE; age = 0; m_dsel = 1'b0; m_pos = 3'd0; m_rt = 0;
            m_score = 0; m_best = 1023; m_round = 0; m_lfsr = 8'hA5;
            e_rst_t = 1'b0; e_miss = 1'b0; e_over = 1'b0; e_mole = 8'd0;
        end else begin
            live = (age != 0);
            np = ph;
            case (ph)
                P_IDLE, P_DONE: if (start) np = P_DELAY;
                P_DELAY: begin
                    if (whack) np = P_MISS;
                    else if (live && (m_dsel ? timer_3_edge : timer_1_edge)) np = P_MOLE;
                end
                P_MOLE: begin
                    if (whack) np = P_HIT;
                    else if (live && timer_1_edge) np = P_MISS;
                end
                default: begin
                    if (live && timer_0point2_edge) np = (m_round + 1 == ROUNDS) ? P_DONE : P_DELAY;
                end
            endcase
            e_mole  = (ph == P_MOLE || ph == P_HIT) ? (8'd1 << m_pos) : 8'd0;
            e_miss  = (ph == P_MISS);
            e_over  = (ph == P_DONE);
            e_rst_t = (np != ph) && (np >= P_DELAY) && (np <= P_MISS);
            if (ph == P_HIT && age == 0) begin
                m_score = (m_score >= 15) ? 15 : m_score + 1;
                if (m_rt < m_best) m_best = m_rt;
            end
            if ((ph == P_HIT || ph == P_MISS) && np != ph) m_round = m_round + 1;
            if (ph == P_MOLE && np == P_HIT) m_rt = int'(display_timer);
            if ((ph == P_IDLE || ph == P_DONE) && np == P_DELAY) begin
                m_score = 0; m_round = 0; m_best = 1023;
            end
            if (np == P_DELAY && np != ph) begin
                m_dsel = m_lfsr[7];
                m_pos  = m_lfsr[2:0];
            end
            age = (np != ph) ? 0 : age + 1;
            ph  = np;
            fb  = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
            m_lfsr = {m_lfsr[6:0], fb};
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("cyc_reset_timer", 32'(reset_timer), 32'(e_rst_t));
        chk("cyc_mole_led",    32'(mole_led),    32'(e_mole));
        chk("cyc_miss_led",    32'(miss_led),    32'(e_miss));
        chk("cyc_game_over",   32'(game_over),   32'(e_over));
        chk("cyc_score",       32'(score),       32'(m_score));
        chk("cyc_best_time",   32'(best_time),   32'(m_best));
        chk("cyc_round_num",   32'(round_num),   32'(m_round));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic w, input logic t02, input logic t1,
                        input logic t3, input logic [9:0] dt);
        @(negedge clk);
        start = s; whack = w; timer_0point2_edge = t02;
        timer_1_edge = t1; timer_3_edge = t3; display_timer = dt;
        @(posedge clk);
        #1;
        start = 1'b0; whack = 1'b0; timer_0point2_edge = 1'b0;
        timer_1_edge = 1'b0; timer_3_edge = 1'b0;
    endtask

    // From a DELAY entry cycle, fire whichever timer edge the latched wait length needs.
    task automatic enter_mole();
        step(0, 0, 0, 0, 0, 10'd0);
        step(0, 0, 0, !m_dsel, m_dsel, 10'd0);
    endtask

    task automatic hit(input logic [9:0] dt, input logic with_t1);
        enter_mole();
        step(0, 0, 0, 0, 0, 10'd0);
        step(0, 1, 0, with_t1, 0, dt);
        step(0, 0, 0, 0, 0, 10'd0);
        step(0, 0, 1, 0, 0, 10'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mole_led",  32'(mole_led),  0);
        chk("rst_score",     32'(score),     0);
        chk("rst_best_time", 32'(best_time), 1023);
        chk("rst_round_num", 32'(round_num), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_miss_led",  32'(miss_led),  0);
        reset_n = 1'b1;

        // Game 1, round 1: LFSR is 0x4A at start, so short wait and mole 2.
        step(1, 0, 0, 0, 0, 10'd0);
        chk("g1_rt_delay_entry", 32'(reset_timer), 1);
        chk("g1_model_dsel",     32'(m_dsel), 0);
        chk("g1_model_pos",      32'(m_pos),  2);
        step(0, 0, 0, 1, 1, 10'd0);               // edges in entry cycle are stale
        chk("g1_entry_edge_ign", 32'(reset_timer), 0);
        step(1, 0, 0, 0, 0, 10'd0);               // start ignored mid-game
        step(0, 0, 0, 1, 0, 10'd0);
        chk("g1_rt_mole_entry",  32'(reset_timer), 1);
        step(0, 0, 0, 0, 0, 10'd0);
        chk("g1_mole_led",       32'(mole_led), 4);
        step(0, 1, 0, 0, 0, 10'd37);
        chk("g1_rt_hit_entry",   32'(reset_timer), 1);
        step(0, 0, 0, 0, 0, 10'd0);
        chk("g1_score",          32'(score), 1);
        chk("g1_best_time",      32'(best_time), 37);
        step(0, 0, 1, 0, 0, 10'd0);
        chk("g1_round1",         32'(round_num), 1);

        // Round 2: mole times out.
        enter_mole();
        step(0, 0, 0, 0, 0, 10'd0);
        step(0, 0, 0, 1, 0, 10'd0);
        chk("g1_rt_miss_entry",  32'(reset_timer), 1);
        step(0, 0, 0, 0, 0, 10'd0);
        chk("g1_miss_led",       32'(miss_led), 1);
        chk("g1_miss_score",     32'(score), 1);
        step(0, 0, 1, 0, 0, 10'd0);
        chk("g1_round2",         32'(round_num), 2);

        // Round 3: early whack during the wait.
        step(0, 1, 0, 0, 0, 10'd0);
        step(0, 0, 0, 0, 0, 10'd0);
        chk("g1_early_miss_led", 32'(miss_led), 1);
        chk("g1_early_mole_off", 32'(mole_led), 0);
        step(0, 0, 1, 0, 0, 10'd0);
        step(0, 0, 0, 0, 0, 10'd0);
        chk("g1_game_over",      32'(game_over), 1);
        chk("g1_final_round",    32'(round_num), 3);
        chk("g1_final_best",     32'(best_time), 37);
        step(0, 1, 1, 1, 1, 10'd0);               // ignored in DONE
        chk("g1_done_held",      32'(round_num), 3);

        // Game 2: three hits, second one with a simultaneous timeout edge.
        step(1, 0, 0, 0, 0, 10'd0);
        chk("g2_clear_score",    32'(score), 0);
        chk("g2_clear_round",    32'(round_num), 0);
        chk("g2_clear_best",     32'(best_time), 1023);
        hit(10'd50, 1'b0);
        hit(10'd20, 1'b1);
        chk("g2_tie_hit_score",  32'(score), 2);
        hit(10'd80, 1'b0);
        step(0, 0, 0, 0, 0, 10'd0);
        chk("g2_game_over",      32'(game_over), 1);
        chk("g2_score",          32'(score), 3);
        chk("g2_best_time",      32'(best_time), 20);
        step(1, 0, 0, 0, 0, 10'd0);
        chk("g2_restart_score",  32'(score), 0);

        // Game 3: reset while the mole is lit.
        hit(10'd15, 1'b0);
        enter_mole();
        step(0, 0, 0, 0, 0, 10'd0);
        step(0, 0, 0, 0, 0, 10'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_mole_led",    32'(mole_led), 0);
        chk("async_score",       32'(score), 0);
        chk("async_best_time",   32'(best_time), 1023);
        chk("async_round",       32'(round_num), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(1, 0, 0, 0, 0, 10'd0);
        chk("post_rst_pos",      32'(m_pos), 2);
        enter_mole();
        step(0, 0, 0, 0, 0, 10'd0);
        chk("post_rst_mole_led", 32'(mole_led), 4);
        step(0, 1, 0, 0, 0, 10'd5);
        step(0, 0, 0, 0, 0, 10'd0);
        chk("post_rst_score",    32'(score), 1);
        chk("post_rst_best",     32'(best_time), 5);
        step(0, 0, 0, 0, 0, 10'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
